// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with debounced SW8 start/wait control.
module pc_sequencer #(
    parameter int Psize     = 6,
    parameter int LAST_ADDR = 2**Psize-1,
    parameter int DB_CYCLES = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             sw8_raw,
    input  logic             wait_hi,
    input  logic             wait_lo,
    input  logic             jump_en,
    input  logic [Psize-1:0] jump_addr,
    input  logic             halt_req,
    output logic [Psize-1:0] PCout,
    output logic             stall,
    output logic [1:0]       state,
    output logic             sw8_clean,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, WAIT = 2'b10, HALT = 2'b11} state_t;
    localparam logic [Psize-1:0] LAST    = Psize'(LAST_ADDR);
    localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);

    state_t           state_q;
    logic [Psize-1:0] pc_q, pc_inc, jump_tgt;
    logic [7:0]       db_cnt_q, db_cnt_d;
    logic             sync1_q, sync2_q, clean_q, clean_d, wrap_q, target_q;
    logic             differ, db_hit, at_last, wait_stall, wait_exit;

    always_comb begin
        differ     = sync2_q != clean_q;
        db_hit     = differ && (db_cnt_q == DB_LAST);
        clean_d    = clean_q ^ db_hit;
        db_cnt_d   = (differ && !db_hit) ? db_cnt_q + 8'd1 : 8'd0;
        at_last    = pc_q == LAST;
        pc_inc     = at_last ? '0 : pc_q + 1'b1;
        jump_tgt   = (jump_addr > LAST) ? '0 : jump_addr;
        // wait_hi takes precedence when both wait classes are requested
        wait_stall = wait_hi ? !clean_q : (wait_lo && clean_q);
        wait_exit  = clean_d == target_q;
        stall      = (state_q == IDLE) || (state_q == HALT) ||
                     (state_q == WAIT && !wait_exit) ||
                     (state_q == RUN && (halt_req || wait_stall));
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            clean_q  <= 1'b0;
            state_q  <= IDLE;
            pc_q     <= '0;
            wrap_q   <= 1'b0;
            target_q <= 1'b0;
        end else begin
            sync1_q  <= sw8_raw;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            clean_q  <= clean_d;
            wrap_q   <= 1'b0;
            case (state_q)
                IDLE: if (db_hit && !clean_q) state_q <= RUN;
                RUN: begin
                    if (halt_req) state_q <= HALT;
                    else if (wait_stall) begin
                        state_q  <= WAIT;
                        target_q <= wait_hi;
                    end else if (jump_en) pc_q <= jump_tgt;
                    else begin
                        pc_q   <= pc_inc;
                        wrap_q <= at_last;
                    end
                end
                WAIT: if (wait_exit) begin
                    state_q <= RUN;
                    pc_q    <= pc_inc;
                    wrap_q  <= at_last;
                end
                HALT: ;
            endcase
        end
    end

    assign PCout     = pc_q;
    assign state     = state_q;
    assign sw8_clean = clean_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios for pc_sequencer with LAST_ADDR=5, DB_CYCLES=8.
module tb_pc_sequencer;
    logic       clk = 1'b0, nReset = 1'b0, sw8_raw = 1'b0;
    logic       wait_hi = 1'b0, wait_lo = 1'b0, jump_en = 1'b0, halt_req = 1'b0;
    logic [5:0] jump_addr = '0;
    logic [5:0] PCout;
    logic       stall, sw8_clean, wrap;
    logic [1:0] state;
    int total = 0, bad = 0;

    pc_sequencer #(.Psize(6), .LAST_ADDR(5), .DB_CYCLES(8)) dut (
        .clk(clk), .nReset(nReset), .sw8_raw(sw8_raw), .wait_hi(wait_hi), .wait_lo(wait_lo),
        .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req), .PCout(PCout),
        .stall(stall), .state(state), .sw8_clean(sw8_clean), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (PCout !== 6'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", PCout); end
        total++; if (sw8_clean !== 1'b0) begin bad++; $display("FAIL reset_clean got=%0b want=0", sw8_clean); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%0b want=1", stall); end
        #2 nReset = 1'b1;
        step();
    endtask

    task automatic test_glitch;
        sw8_raw = 1'b1;
        step(5);
        sw8_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++; if (sw8_clean !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL glitch cyc=%0d clean=%0b state=%0d want clean=0 state=0", i, sw8_clean, state); end
        end
    endtask

    task automatic test_start_and_wrap;
        sw8_raw = 1'b1;
        step(9);
        total++; if (sw8_clean !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL start_early clean=%0b state=%0d want clean=0 state=0", sw8_clean, state); end
        step();
        total++; if (sw8_clean !== 1'b1 || state !== 2'd1) begin bad++; $display("FAIL start_edge clean=%0b state=%0d want clean=1 state=1", sw8_clean, state); end
        total++; if (PCout !== 6'd0 || stall !== 1'b0) begin bad++; $display("FAIL start_pc pc=%0d stall=%0b want pc=0 stall=0", PCout, stall); end
        for (int i = 1; i <= 7; i++) begin
            step();
            total++; if (PCout !== 6'(i % 6) || wrap !== (i == 6)) begin bad++; $display("FAIL freerun i=%0d pc=%0d wrap=%0b want pc=%0d wrap=%0b", i, PCout, wrap, i % 6, i == 6); end
        end
    endtask

    task automatic test_jump;
        jump_en = 1'b1; jump_addr = 6'd7;
        step();
        total++; if (PCout !== 6'd0 || wrap !== 1'b0) begin bad++; $display("FAIL jump_over pc=%0d wrap=%0b want pc=0 wrap=0", PCout, wrap); end
        jump_addr = 6'd4;
        step();
        total++; if (PCout !== 6'd4) begin bad++; $display("FAIL jump_4 got=%0d want=4", PCout); end
        jump_addr = 6'd5;
        step();
        total++; if (PCout !== 6'd5 || wrap !== 1'b0) begin bad++; $display("FAIL jump_last pc=%0d wrap=%0b want pc=5 wrap=0", PCout, wrap); end
        jump_en = 1'b0;
        step();
        total++; if (PCout !== 6'd0 || wrap !== 1'b1) begin bad++; $display("FAIL wrap_after_jump pc=%0d wrap=%0b want pc=0 wrap=1", PCout, wrap); end
    endtask

    task automatic test_wait_satisfied;
        wait_hi = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sat_hi_stall got=%0b want=0", stall); end
        step();
        total++; if (PCout !== 6'd1 || state !== 2'd1) begin bad++; $display("FAIL sat_hi pc=%0d state=%0d want pc=1 state=1", PCout, state); end
        wait_lo = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL both_wait_stall got=%0b want=0", stall); end
        step();
        total++; if (PCout !== 6'd2 || state !== 2'd1) begin bad++; $display("FAIL both_wait pc=%0d state=%0d want pc=2 state=1", PCout, state); end
        wait_hi = 1'b0; wait_lo = 1'b0;
    endtask

    task automatic test_wait_lo;
        jump_en = 1'b1; jump_addr = 6'd3;
        step();
        jump_en = 1'b0; wait_lo = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL wait_enter_stall got=%0b want=1", stall); end
        step();
        wait_lo = 1'b0; sw8_raw = 1'b0;
        total++; if (state !== 2'd2 || PCout !== 6'd3 || stall !== 1'b1) begin bad++; $display("FAIL wait_entered state=%0d pc=%0d stall=%0b want 2/3/1", state, PCout, stall); end
        step(8);
        total++; if (state !== 2'd2 || PCout !== 6'd3 || stall !== 1'b1) begin bad++; $display("FAIL wait_hold state=%0d pc=%0d stall=%0b want 2/3/1", state, PCout, stall); end
        step();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL wait_exit_stall got=%0b want=0", stall); end
        step();
        total++; if (state !== 2'd1 || PCout !== 6'd4 || sw8_clean !== 1'b0) begin bad++; $display("FAIL wait_exit state=%0d pc=%0d clean=%0b want 1/4/0", state, PCout, sw8_clean); end
    endtask

    task automatic test_reset_mid_wait;
        wait_hi = 1'b1;
        step();
        wait_hi = 1'b0; sw8_raw = 1'b1;
        step(6);
        total++; if (state !== 2'd2 || PCout !== 6'd4) begin bad++; $display("FAIL hi_wait state=%0d pc=%0d want 2/4", state, PCout); end
        nReset = 1'b0;
        #1;
        total++; if (state !== 2'd0 || PCout !== 6'd0 || sw8_clean !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL async_reset state=%0d pc=%0d clean=%0b wrap=%0b want all 0", state, PCout, sw8_clean, wrap); end
        @(posedge clk);
        #2 nReset = 1'b1;
        step(9);
        total++; if (state !== 2'd0 || PCout !== 6'd0 || sw8_clean !== 1'b0) begin bad++; $display("FAIL post_reset_idle state=%0d pc=%0d clean=%0b want 0/0/0", state, PCout, sw8_clean); end
        step();
        total++; if (state !== 2'd1 || sw8_clean !== 1'b1) begin bad++; $display("FAIL post_reset_start state=%0d clean=%0b want 1/1", state, sw8_clean); end
    endtask

    task automatic test_halt;
        sw8_raw = 1'b0;
        step(10);
        jump_en = 1'b1; jump_addr = 6'd2;
        step();
        total++; if (PCout !== 6'd2 || sw8_clean !== 1'b0) begin bad++; $display("FAIL pre_halt pc=%0d clean=%0b want 2/0", PCout, sw8_clean); end
        halt_req = 1'b1; wait_hi = 1'b1; jump_addr = 6'd1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL halt_stall_comb got=%0b want=1", stall); end
        step();
        halt_req = 1'b0; wait_hi = 1'b0; jump_en = 1'b0;
        total++; if (state !== 2'd3 || PCout !== 6'd2 || stall !== 1'b1) begin bad++; $display("FAIL halt state=%0d pc=%0d stall=%0b want 3/2/1", state, PCout, stall); end
        sw8_raw = 1'b1;
        step(12);
        sw8_raw = 1'b0;
        step(12);
        total++; if (state !== 2'd3 || PCout !== 6'd2 || stall !== 1'b1) begin bad++; $display("FAIL halt_sticky state=%0d pc=%0d stall=%0b want 3/2/1", state, PCout, stall); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_and_wrap();
        test_jump();
        test_wait_satisfied();
        test_wait_lo();
        test_reset_mid_wait();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
